// File: rtl/floor_call_bank.sv
// Pending elevator call register bank: car, hall-up and hall-down masks with
// set-on-press, direction-aware clear-on-service and position summaries.
module floor_call_bank #(
  parameter int FLOORS = 8,
  parameter int FW     = 3,
  parameter int CW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] car_set,
  input  logic [FLOORS-1:0] up_set,
  input  logic [FLOORS-1:0] dn_set,
  input  logic [FW-1:0]     cur_floor,
  input  logic              arrive,
  input  logic              dir_up,
  output logic [FLOORS-1:0] car_mask,
  output logic [FLOORS-1:0] up_mask,
  output logic [FLOORS-1:0] dn_mask,
  output logic              call_any,
  output logic              above_any,
  output logic              below_any,
  output logic              at_floor_hit,
  output logic [CW-1:0]     pending_cnt,
  output logic              svc_done
);

  localparam logic [FLOORS-1:0] ONE         = FLOORS'(1);
  localparam logic [FLOORS-1:0] TOP_BIT     = ONE << (FLOORS - 1);
  localparam logic [FW:0]       FLOOR_LIMIT = (FW + 1)'(FLOORS);

  logic [FLOORS-1:0] carMask_q, carMask_d;
  logic [FLOORS-1:0] upMask_q, upMask_d;
  logic [FLOORS-1:0] dnMask_q, dnMask_d;
  logic              svcDone_q, svcDone_d;

  logic              inRange;
  logic              serviceHit;
  logic [FLOORS-1:0] anyMask;
  logic [FLOORS-1:0] selVec;
  logic [FLOORS-1:0] belowVec;
  logic [FLOORS-1:0] aboveVec;
  logic [FLOORS-1:0] carClr, upClr, dnClr;
  logic [CW-1:0]     callCount;

  // An out-of-range position is treated as above every floor, so all calls read as below.
  assign inRange    = {1'b0, cur_floor} < FLOOR_LIMIT;
  assign serviceHit = arrive & inRange;
  assign anyMask    = carMask_q | upMask_q | dnMask_q;
  assign selVec     = inRange ? (ONE << cur_floor) : '0;
  assign belowVec   = inRange ? (selVec - ONE) : '1;
  assign aboveVec   = inRange ? ~(belowVec | selVec) : '0;

  assign call_any     = |anyMask;
  assign above_any    = |(anyMask & aboveVec);
  assign below_any    = |(anyMask & belowVec);
  assign at_floor_hit = |(anyMask & selVec);

  // Opposite-direction hall call is also served when nothing remains ahead (reversal).
  always_comb begin
    carClr = '0;
    upClr  = '0;
    dnClr  = '0;
    if (serviceHit) begin
      carClr = selVec;
      if (dir_up || !below_any) upClr = selVec;
      if (!dir_up || !above_any) dnClr = selVec;
    end
    carMask_d = (carMask_q | car_set) & ~carClr;
    upMask_d  = (upMask_q | (up_set & ~TOP_BIT)) & ~upClr;
    dnMask_d  = (dnMask_q | (dn_set & ~ONE)) & ~dnClr;
    svcDone_d = |((carMask_q & carClr) | (upMask_q & upClr) | (dnMask_q & dnClr));
  end

  always_comb begin
    callCount = '0;
    for (int i = 0; i < FLOORS; i++) begin
      callCount = callCount + CW'(carMask_q[i]) + CW'(upMask_q[i]) + CW'(dnMask_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carMask_q <= '0;
      upMask_q  <= '0;
      dnMask_q  <= '0;
      svcDone_q <= 1'b0;
    end else begin
      carMask_q <= carMask_d;
      upMask_q  <= upMask_d;
      dnMask_q  <= dnMask_d;
      svcDone_q <= svcDone_d;
    end
  end

  assign car_mask    = carMask_q;
  assign up_mask     = upMask_q;
  assign dn_mask     = dnMask_q;
  assign pending_cnt = callCount;
  assign svc_done    = svcDone_q;

endmodule

// File: tb/tb_floor_call_bank.sv
// Bench for floor_call_bank: per-floor behavioural model compared every cycle,
// plus literal expectations for the 8-floor and a 10-floor instance.
module tb_floor_call_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] carSet, upSet, dnSet;
  logic [2:0] curFloor;
  logic       arrive, dirUp;
  logic [7:0] carMask, upMask, dnMask;
  logic       callAny, aboveAny, belowAny, atFloorHit, svcDone;
  logic [4:0] pendingCnt;

  logic [9:0] carSet2, upSet2, dnSet2;
  logic [3:0] curFloor2;
  logic       arrive2, dirUp2;
  logic [9:0] carMask2, upMask2, dnMask2;
  logic       callAny2, aboveAny2, belowAny2, atFloorHit2, svcDone2;
  logic [4:0] pendingCnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  floor_call_bank dut (
    .clk(clk), .reset(reset), .car_set(carSet), .up_set(upSet), .dn_set(dnSet),
    .cur_floor(curFloor), .arrive(arrive), .dir_up(dirUp),
    .car_mask(carMask), .up_mask(upMask), .dn_mask(dnMask),
    .call_any(callAny), .above_any(aboveAny), .below_any(belowAny),
    .at_floor_hit(atFloorHit), .pending_cnt(pendingCnt), .svc_done(svcDone)
  );

  floor_call_bank #(.FLOORS(10), .FW(4), .CW(5)) dut10 (
    .clk(clk), .reset(reset), .car_set(carSet2), .up_set(upSet2), .dn_set(dnSet2),
    .cur_floor(curFloor2), .arrive(arrive2), .dir_up(dirUp2),
    .car_mask(carMask2), .up_mask(upMask2), .dn_mask(dnMask2),
    .call_any(callAny2), .above_any(aboveAny2), .below_any(belowAny2),
    .at_floor_hit(atFloorHit2), .pending_cnt(pendingCnt2), .svc_done(svcDone2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-floor model of the pending calls: each floor remembers its three buttons.
  bit mCar[8], mUp[8], mDn[8];
  bit nCar[8], nUp[8], nDn[8];
  bit mSvc, started;
  bit mAbove, mBelow, mCleared;
  int mf;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mCar[i] <= 1'b0; mUp[i] <= 1'b0; mDn[i] <= 1'b0;
      end
      mSvc <= 1'b0;
    end else begin
      mf = int'(curFloor);
      mAbove = 1'b0;
      mBelow = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (mCar[i] || mUp[i] || mDn[i]) begin
          if (i > mf) mAbove = 1'b1;
          if (i < mf) mBelow = 1'b1;
        end
        nCar[i] = mCar[i] || carSet[i];
        nUp[i]  = mUp[i] || (upSet[i] && i != 7);
        nDn[i]  = mDn[i] || (dnSet[i] && i != 0);
      end
      mCleared = 1'b0;
      if (arrive) begin
        if (mCar[mf]) mCleared = 1'b1;
        nCar[mf] = 1'b0;
        if (dirUp) begin
          if (mUp[mf]) mCleared = 1'b1;
          nUp[mf] = 1'b0;
          if (!mAbove) begin
            if (mDn[mf]) mCleared = 1'b1;
            nDn[mf] = 1'b0;
          end
        end else begin
          if (mDn[mf]) mCleared = 1'b1;
          nDn[mf] = 1'b0;
          if (!mBelow) begin
            if (mUp[mf]) mCleared = 1'b1;
            nUp[mf] = 1'b0;
          end
        end
      end
      for (int i = 0; i < 8; i++) begin
        mCar[i] <= nCar[i]; mUp[i] <= nUp[i]; mDn[i] <= nDn[i];
      end
      mSvc <= mCleared;
    end
    started <= 1'b1;
  end

  function automatic logic [7:0] packMask(input bit m[8]);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m[i];
    return v;
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(mCar[i]) + int'(mUp[i]) + int'(mDn[i]);
    return n;
  endfunction

  // rel: 1 = floors above cur_floor, -1 = below, 0 = at cur_floor, 2 = anywhere
  function automatic bit modelAny(input int rel);
    bit hit = 1'b0;
    int f = int'(curFloor);
    for (int i = 0; i < 8; i++) begin
      if (mCar[i] || mUp[i] || mDn[i]) begin
        if (rel == 2) hit = 1'b1;
        if (rel == 1 && i > f) hit = 1'b1;
        if (rel == -1 && i < f) hit = 1'b1;
        if (rel == 0 && i == f) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  always @(posedge clk) begin
    #1;
    if (started) begin
      checkOutput("cmp_car_mask", 32'(carMask), 32'(packMask(mCar)));
      checkOutput("cmp_up_mask", 32'(upMask), 32'(packMask(mUp)));
      checkOutput("cmp_dn_mask", 32'(dnMask), 32'(packMask(mDn)));
      checkOutput("cmp_call_any", 32'(callAny), 32'(modelAny(2)));
      checkOutput("cmp_above_any", 32'(aboveAny), 32'(modelAny(1)));
      checkOutput("cmp_below_any", 32'(belowAny), 32'(modelAny(-1)));
      checkOutput("cmp_at_floor", 32'(atFloorHit), 32'(modelAny(0)));
      checkOutput("cmp_pending", 32'(pendingCnt), 32'(modelCount()));
      checkOutput("cmp_svc_done", 32'(svcDone), 32'(mSvc));
    end
  end

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] u, input logic [7:0] d,
                               input logic [2:0] f, input logic a, input logic dir);
    carSet = c; upSet = u; dnSet = d; curFloor = f; arrive = a; dirUp = dir;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    carSet2 = '0; upSet2 = '0; dnSet2 = '0; curFloor2 = '0; arrive2 = 1'b0; dirUp2 = 1'b0;
    applyStimulus(8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_car", 32'(carMask), 32'h0);
    checkOutput("reset_pending", 32'(pendingCnt), 32'h0);
    checkOutput("reset_call_any", 32'(callAny), 32'h0);
    checkOutput("reset_svc", 32'(svcDone), 32'h0);
    reset = 1'b0;

    applyStimulus(8'h24, 8'h81, 8'h03, 3'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    checkOutput("set_car", 32'(carMask), 32'h24);
    checkOutput("set_up_filter", 32'(upMask), 32'h01);
    checkOutput("set_dn_filter", 32'(dnMask), 32'h02);
    checkOutput("set_pending", 32'(pendingCnt), 32'd4);
    checkOutput("sum_above_f2", 32'(aboveAny), 32'h1);
    checkOutput("sum_below_f2", 32'(belowAny), 32'h1);
    checkOutput("sum_at_f2", 32'(atFloorHit), 32'h1);
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0);
    #1;
    checkOutput("sum_above_f6", 32'(aboveAny), 32'h0);
    checkOutput("sum_at_f6", 32'(atFloorHit), 32'h0);
    tick();

    doReset();
    applyStimulus(8'h20, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    checkOutput("dir_up_mask", 32'(upMask), 32'h00);
    checkOutput("dir_dn_kept", 32'(dnMask), 32'h08);
    checkOutput("dir_car_kept", 32'(carMask), 32'h20);
    checkOutput("dir_svc", 32'(svcDone), 32'h1);
    tick();
    checkOutput("dir_svc_one_cycle", 32'(svcDone), 32'h0);

    doReset();
    applyStimulus(8'h00, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    checkOutput("rev_up", 32'(upMask), 32'h00);
    checkOutput("rev_dn", 32'(dnMask), 32'h00);
    checkOutput("rev_pending", 32'(pendingCnt), 32'h0);
    checkOutput("rev_svc", 32'(svcDone), 32'h1);

    applyStimulus(8'h01, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    checkOutput("down_up_kept", 32'(upMask), 32'h08);
    checkOutput("down_dn_clr", 32'(dnMask), 32'h00);

    doReset();
    applyStimulus(8'h20, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h20, 8'h00, 8'h00, 3'd5, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
    checkOutput("collide_car", 32'(carMask), 32'h00);
    checkOutput("collide_svc", 32'(svcDone), 32'h1);
    applyStimulus(8'h10, 8'h00, 8'h00, 3'd4, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
    checkOutput("collide_empty_svc", 32'(svcDone), 32'h0);

    applyStimulus(8'h0C, 8'h40, 8'h80, 3'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd2, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b1, 1'b1);
    tick();
    checkOutput("b2b_svc", 32'(svcDone), 32'h1);
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd7, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd6, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h02, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
    checkOutput("midreset_svc", 32'(svcDone), 32'h0);
    tick();
    checkOutput("midreset_no_pulse", 32'(svcDone), 32'h0);

    carSet2 = 10'h200; upSet2 = 10'h201; dnSet2 = 10'h001; curFloor2 = 4'd12;
    tick();
    carSet2 = '0; upSet2 = '0; dnSet2 = '0;
    checkOutput("f10_up_filter", 32'(upMask2), 32'h001);
    checkOutput("f10_dn_filter", 32'(dnMask2), 32'h000);
    checkOutput("f10_below_any", 32'(belowAny2), 32'h1);
    checkOutput("f10_above_any", 32'(aboveAny2), 32'h0);
    checkOutput("f10_at_floor", 32'(atFloorHit2), 32'h0);
    arrive2 = 1'b1; dirUp2 = 1'b1;
    tick();
    arrive2 = 1'b0;
    checkOutput("f10_range_car", 32'(carMask2), 32'h200);
    checkOutput("f10_range_up", 32'(upMask2), 32'h001);
    checkOutput("f10_range_svc", 32'(svcDone2), 32'h0);
    checkOutput("f10_pending", 32'(pendingCnt2), 32'd2);
    curFloor2 = 4'd9; arrive2 = 1'b1; dirUp2 = 1'b1;
    tick();
    arrive2 = 1'b0;
    checkOutput("f10_top_clear", 32'(carMask2), 32'h000);
    checkOutput("f10_top_svc", 32'(svcDone2), 32'h1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floor_call_bank.md
Name: floor_call_bank

Overview:
- Parametrised successor to the fixed 8-floor call register file.
- Holds the elevator's pending car calls, hall-up calls and hall-down calls for FLOORS floors as three registered bit masks.
- Provides set-on-press and clear-on-service with direction-aware reversal.
- Publishes above/below/at-floor summaries and a pending-call count for the car controller FSM.

Parameters:
- FLOORS, 8, number of floors; bit i of every mask is floor i, highest floor is MSB.
- FW, 3, floor index width; must satisfy 2^FW >= FLOORS.
- CW, 5, pending-count width; must satisfy 2^CW > 3*FLOORS.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clock clk
- car_set  input  FLOORS  car-panel button pulses, one bit per floor
- up_set  input  FLOORS  hall up-button pulses
- dn_set  input  FLOORS  hall down-button pulses
- cur_floor  input  FW  floor the car is at or passing
- arrive  input  1  single-cycle pulse: car stopped at cur_floor, doors opening
- dir_up  input  1  travel direction at arrival; 1 = up, 0 = down
- car_mask  output  FLOORS  registered pending car calls
- up_mask  output  FLOORS  registered pending hall-up calls
- dn_mask  output  FLOORS  registered pending hall-down calls
- call_any  output  1  OR of all three masks
- above_any  output  1  any pending call at a floor > cur_floor
- below_any  output  1  any pending call at a floor < cur_floor
- at_floor_hit  output  1  any pending call at cur_floor
- pending_cnt  output  CW  popcount of car_mask, up_mask and dn_mask together
- svc_done  output  1  registered pulse: previous-cycle arrive cleared at least one bit

Behaviour:
- Reset (sync, priority over everything):
  - All masks go to 0 and svc_done goes to 0.
  - Derived outputs therefore read 0.
  - Set pulses in a reset cycle are discarded.
- Set path:
  - Each cycle: car_mask <= car_mask | car_set; up_mask <= up_mask | up_set; dn_mask <= dn_mask | dn_set.
  - One-cycle latency from press to mask bit.
  - Repeated presses are idempotent.
- Illegal hall calls are ignored and never stored:
  - up_set[FLOORS-1] (top floor).
  - dn_set[0] (bottom floor).
- Service clear: applies when arrive=1 and cur_floor < FLOORS; call this floor f.
  - Always clear car_mask[f].
  - dir_up=1: clear up_mask[f]. Also clear dn_mask[f] if no call of any type exists above f.
  - dir_up=0: clear dn_mask[f]. Also clear up_mask[f] if no call exists below f.
  - The "exists above/below" test uses pre-edge registered masks only. Same-cycle sets are not included.
- Simultaneous set and clear on the same bit in the same cycle: clear wins. Rationale: the button at the open-door floor is already serviced.
- Out of range, cur_floor >= FLOORS:
  - arrive is ignored, nothing cleared and svc_done stays 0.
  - at_floor_hit = 0 and above_any = 0.
  - below_any = call_any.
- Derived outputs (combinational from registered masks and cur_floor; no added latency):
  - call_any, above_any, below_any, at_floor_hit, pending_cnt.
  - pending_cnt range is 0..3*FLOORS-2.
- svc_done:
  - Goes to 1 for exactly one cycle, the cycle after an arrive that changed at least one mask bit from 1 to 0.
  - Otherwise 0.
  - Back-to-back arrive pulses give back-to-back svc_done pulses.
- Reset asserted mid-service: svc_done is forced to 0 on the next edge; there is no pending pulse after reset releases.

Test Plan:
- Reset: assert reset 2 cycles with car_set=8'hFF held -> all masks 0, pending_cnt=0, call_any=0, svc_done=0.
- Set and illegal filter: pulse car_set=8'h24, up_set=8'h81, dn_set=8'h03 -> next cycle car_mask=8'h24, up_mask=8'h01, dn_mask=8'h02, pending_cnt=4.
- Summaries: masks from the previous test, cur_floor=2 -> above_any=1, below_any=1, at_floor_hit=1; cur_floor=6 -> above_any=0, at_floor_hit=0.
- Directional clear: car_mask=8'h20, up_mask=8'h08, dn_mask=8'h08, cur_floor=3, arrive with dir_up=1 -> up_mask=0, dn_mask=8'h08 kept (call above exists), svc_done=1 one cycle later.
- Reversal clear: only up_mask=8'h08 and dn_mask=8'h08 pending, cur_floor=3, arrive with dir_up=1 -> both masks 0, pending_cnt=0, svc_done pulse.
- Collision and range:
  - arrive at cur_floor=5 together with car_set[5]=1 -> car_mask[5]=0.
  - FLOORS=10, FW=4, cur_floor=12, arrive=1 -> masks unchanged, svc_done=0, below_any=call_any.
